// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-side definitions: PC select encodings, controller states and
// the register-hit helper used by the hazard logic.
package fetch_pkg;

   // PC register source select
   localparam logic [1:0] PC_SEQ  = 2'b00;
   localparam logic [1:0] PC_JUMP = 2'b01;
   localparam logic [1:0] PC_BEQ  = 2'b10;
   localparam logic [1:0] PC_JR   = 2'b11;

   typedef enum logic [1:0] {
      BOOT = 2'b00,
      RUN  = 2'b01,
      PEND = 2'b10
   } fetch_state_t;

   // A nonzero destination r matches a source the ID instruction actually reads
   function automatic logic reg_hit(input logic [4:0] r, input logic [4:0] rs,
                                    input logic [4:0] rt, input logic cmp_rt);
      return (r != 5'd0) && ((r == rs) || (cmp_rt && (r == rt)));
   endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bundle of ID/EX/MEM hazard fields, imem handshake and PC/pipeline controls
// seen by the fetch controller.
interface fetch_ctrl_if #(
   parameter int PERF_W = 16
);
   logic              imem_ready;
   logic              id_valid;
   logic              id_jump;
   logic              id_beq_taken;
   logic              id_jr;
   logic [4:0]        id_rs;
   logic [4:0]        id_rt;
   logic              id_uses_rt;
   logic [31:0]       id_jr_target;
   logic [31:0]       id_beq_target;
   logic [3:0]        id_pc_4_hi;
   logic [27:0]       id_offset28;
   logic              ex_mem_read;
   logic              ex_reg_write;
   logic [4:0]        ex_dst;
   logic              mem_mem_read;
   logic [4:0]        mem_dst;
   logic              imem_req;
   logic              pc_write;
   logic [1:0]        pc_src;
   logic [31:0]       redir_pc;
   logic              if_id_write;
   logic              if_flush;
   logic              id_ex_bubble;
   logic [PERF_W-1:0] perf_stall;

   // Controller side
   modport master (
      input  imem_ready, id_valid, id_jump, id_beq_taken, id_jr, id_rs, id_rt,
             id_uses_rt, id_jr_target, id_beq_target, id_pc_4_hi, id_offset28,
             ex_mem_read, ex_reg_write, ex_dst, mem_mem_read, mem_dst,
      output imem_req, pc_write, pc_src, redir_pc, if_id_write, if_flush,
             id_ex_bubble, perf_stall
   );

   // Pipeline / memory side
   modport slave (
      output imem_ready, id_valid, id_jump, id_beq_taken, id_jr, id_rs, id_rt,
             id_uses_rt, id_jr_target, id_beq_target, id_pc_4_hi, id_offset28,
             ex_mem_read, ex_reg_write, ex_dst, mem_mem_read, mem_dst,
      input  imem_req, pc_write, pc_src, redir_pc, if_id_write, if_flush,
             id_ex_bubble, perf_stall
   );
endinterface

// File: rtl/fetch_ctrl_hazard_detect.sv
// Combinational hazard detection: load-use against EX, and ID-resolved branch
// operands against in-flight EX results and MEM loads.
module hazard_detect
   import fetch_pkg::*;
(
   input  logic       id_valid_i,
   input  logic       id_beq_taken_i,
   input  logic       id_jr_i,
   input  logic [4:0] id_rs_i,
   input  logic [4:0] id_rt_i,
   input  logic       id_uses_rt_i,
   input  logic       ex_mem_read_i,
   input  logic       ex_reg_write_i,
   input  logic [4:0] ex_dst_i,
   input  logic       mem_mem_read_i,
   input  logic [4:0] mem_dst_i,
   output logic       load_use_o,
   output logic       br_haz_o
);
   logic br_cmp_rt;

   // jr reads only rs and outranks beq, so rt is ignored whenever jr is requested
   always_comb begin
      br_cmp_rt  = id_uses_rt_i && !id_jr_i;
      load_use_o = id_valid_i && ex_mem_read_i &&
                   reg_hit(ex_dst_i, id_rs_i, id_rt_i, id_uses_rt_i);
      br_haz_o   = id_valid_i && (id_beq_taken_i || id_jr_i) &&
                   ((ex_reg_write_i && reg_hit(ex_dst_i, id_rs_i, id_rt_i, br_cmp_rt)) ||
                    (mem_mem_read_i && reg_hit(mem_dst_i, id_rs_i, id_rt_i, br_cmp_rt)));
   end
endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-side controller: resolves ID redirects against imem readiness and
// hazards, drives PC load/select and IF/ID, ID/EX stall/flush controls.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int PERF_W = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   fetch_ctrl_if.master bus
);
   fetch_state_t      state_q, state_d;
   logic [31:0]       pend_pc_q, pend_pc_d;
   logic [PERF_W-1:0] perf_q;
   logic              load_use, br_haz, stall, redirect;
   logic [1:0]        live_src;
   logic [31:0]       live_tgt;

   hazard_detect u_haz (
      .id_valid_i     (bus.id_valid),
      .id_beq_taken_i (bus.id_beq_taken),
      .id_jr_i        (bus.id_jr),
      .id_rs_i        (bus.id_rs),
      .id_rt_i        (bus.id_rt),
      .id_uses_rt_i   (bus.id_uses_rt),
      .ex_mem_read_i  (bus.ex_mem_read),
      .ex_reg_write_i (bus.ex_reg_write),
      .ex_dst_i       (bus.ex_dst),
      .mem_mem_read_i (bus.mem_mem_read),
      .mem_dst_i      (bus.mem_dst),
      .load_use_o     (load_use),
      .br_haz_o       (br_haz)
   );

   assign stall    = load_use || br_haz;
   assign redirect = bus.id_valid && (bus.id_jr || bus.id_beq_taken || bus.id_jump);

   // Live redirect source and target, priority jr > beq > jump
   always_comb begin
      live_src = PC_JUMP;
      live_tgt = {bus.id_pc_4_hi, bus.id_offset28};
      if (bus.id_jr) begin
         live_src = PC_JR;
         live_tgt = bus.id_jr_target;
      end else if (bus.id_beq_taken) begin
         live_src = PC_BEQ;
         live_tgt = bus.id_beq_target;
      end
   end

   // Next state, pending target capture and all control outputs
   always_comb begin
      state_d          = state_q;
      pend_pc_d        = pend_pc_q;
      bus.imem_req     = 1'b0;
      bus.pc_write     = 1'b0;
      bus.pc_src       = PC_SEQ;
      bus.redir_pc     = bus.id_jr_target;
      bus.if_id_write  = 1'b1;
      bus.if_flush     = 1'b0;
      bus.id_ex_bubble = 1'b0;
      unique case (state_q)
         BOOT: begin
            bus.if_flush     = 1'b1;
            bus.id_ex_bubble = 1'b1;
            state_d          = RUN;
         end
         RUN: begin
            bus.imem_req = 1'b1;
            if (stall) begin
               bus.if_id_write  = 1'b0;
               bus.id_ex_bubble = 1'b1;
            end else if (redirect && bus.imem_ready) begin
               // Non-jr sources are computed by the PC register from its own inputs
               bus.pc_write = 1'b1;
               bus.pc_src   = live_src;
               bus.if_flush = 1'b1;
            end else if (redirect) begin
               // Fetch still busy: hold every kind of target and replay it as a jr load
               pend_pc_d    = live_tgt;
               bus.if_flush = 1'b1;
               state_d      = PEND;
            end else begin
               bus.pc_write    = bus.imem_ready;
               bus.if_id_write = bus.imem_ready;
            end
         end
         PEND: begin
            bus.imem_req     = 1'b1;
            bus.redir_pc     = pend_pc_q;
            bus.if_id_write  = 1'b0;
            bus.id_ex_bubble = 1'b1;
            if (bus.imem_ready) begin
               bus.pc_write = 1'b1;
               bus.pc_src   = PC_JR;
               bus.if_flush = 1'b1;
               state_d      = RUN;
            end
         end
         default: state_d = BOOT;
      endcase
   end

   // State and pending-target registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= BOOT;
         pend_pc_q <= '0;
      end else begin
         state_q   <= state_d;
         pend_pc_q <= pend_pc_d;
      end
   end

   // Saturating count of hazard-stall cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_q <= '0;
      end else if ((state_q == RUN) && stall && (perf_q != '1)) begin
         perf_q <= perf_q + PERF_W'(1);
      end
   end

   assign bus.perf_stall = perf_q;

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch-side controller that drives the program counter register's `pc_write`/`pc_src` select and owns its `jr` data input. It resolves ID-stage redirects (jump, taken beq, jr) against instruction-memory readiness and data hazards, and generates the IF/ID and ID/EX stall/flush controls. A redirect that cannot be applied because the fetch is not complete is captured and applied later as a `PC_JR` load of the captured target. It sits between the ID-stage decode/compare logic, the hazard sources in EX/MEM, the instruction memory, and the PC register.

## Interface
Parameters:
- `PERF_W`, 16, width of saturating stall-cycle counter

Ports:
- `clk`  in  1  clock; all state updates on posedge
- `rst_n`  in  1  asynchronous active-low reset
- `imem_ready`  in  1  fetch of current PC completes this cycle
- `id_valid`  in  1  IF/ID holds a real instruction
- `id_jump` / `id_beq_taken` / `id_jr`  in  1 each  ID redirect requests; priority jr > beq > jump
- `id_rs`, `id_rt`  in  5 each  ID source registers
- `id_uses_rt`  in  1  ID instruction reads rt (R-type, beq, sw)
- `id_jr_target`, `id_beq_target`  in  32 each  live ID targets
- `id_pc_4_hi`  in  4  ID-stage PC+4 [31:28]
- `id_offset28`  in  28  jump offset (instr_index << 2)
- `ex_mem_read`, `ex_reg_write`  in  1 each  EX-stage instruction kind
- `ex_dst`  in  5  EX destination register (rt for loads, rd/rt otherwise)
- `mem_mem_read`  in  1  MEM-stage instruction is a load
- `mem_dst`  in  5  MEM destination register
- `imem_req`  out  1  request fetch at current PC
- `pc_write`  out  1  PC load enable
- `pc_src`  out  2  PC select
- `redir_pc`  out  32  drives the PC register's `jr` input
- `if_id_write`  out  1  IF/ID enable
- `if_flush`  out  1  zero IF/ID on next edge
- `id_ex_bubble`  out  1  insert NOP into ID/EX
- `perf_stall`  out  PERF_W  saturating count of hazard-stall cycles

## Operation
- pc_src encodings: `PC_SEQ`=00, `PC_JUMP`=01, `PC_BEQ`=10, `PC_JR`=11.
- `hit(r)` = r != 0 && (r == id_rs || (id_uses_rt && r == id_rt)).
- load_use = id_valid && ex_mem_read && hit(ex_dst).
- br_haz = id_valid && (id_beq_taken || id_jr) && ((ex_reg_write && hit(ex_dst)) || (mem_mem_read && hit(mem_dst))). For jr, only rs is compared.
- stall = load_use || br_haz. A load feeding a branch stalls 2 cycles: first on the EX term, then on the MEM term.
- States: `BOOT`, `RUN`, `PEND`.
- BOOT (entered on reset): imem_req=0, pc_write=0, if_flush=1, id_ex_bubble=1. Goes to RUN unconditionally on the next edge.
- RUN, imem_req=1, evaluated in this order:
  - stall: pc_write=0, if_id_write=0, id_ex_bubble=1; perf_stall increments, saturating at all-ones.
  - else redirect && imem_ready: pc_write=1; pc_src=live source; redir_pc=id_jr_target; if_flush=1.
  - else redirect && !imem_ready: capture target into `pend_pc` (jump target = {id_pc_4_hi, id_offset28}); pc_write=0; if_flush=1; go to PEND.
  - else: pc_write=imem_ready, pc_src=PC_SEQ, if_id_write=imem_ready, if_flush=0.
- Outside the immediate-redirect case, redir_pc=id_jr_target in RUN.
- PEND:
  - imem_req=1, redir_pc=pend_pc, if_id_write=0, id_ex_bubble=1 (wrong-path fetch discarded).
  - On imem_ready: pc_write=1, pc_src=PC_JR, if_flush=1, go to RUN.
  - ID hazards are ignored in PEND (IF/ID is empty).
- Any output not listed for a state/case: pc_write=0, pc_src=PC_SEQ, if_id_write=1, if_flush=0, id_ex_bubble=0.

## Timing
- All outputs are combinational from state and the current inputs. The PC and pipeline registers sample them on the same posedge.
- Immediate redirect: 1-cycle penalty (one flushed slot).
- Deferred redirect: PC loads on the first edge where imem_ready=1 in PEND.
- Reset values (while rst_n=0): state=BOOT, pend_pc=0, perf_stall=0, imem_req=0, pc_write=0, pc_src=00, redir_pc=id_jr_target, if_id_write=1, if_flush=1, id_ex_bubble=1.
- Reset asserted in PEND drops the pending target.
- Stall and redirect in the same cycle: stall wins; the redirect is re-evaluated next cycle.
- Multiple redirect flags asserted together: priority jr > beq > jump.
- perf_stall does not wrap.

## Structure
- Package `fetch_pkg`: pc_src localparams (PC_SEQ/JUMP/BEQ/JR) and the state encoding (BOOT/RUN/PEND); shared with the PC register and the decoder.
- Sub-module `hazard_detect`: purely combinational; produces load_use and br_haz from the ID/EX/MEM fields.
- The top-level FSM, pend_pc, and perf counter stay in `fetch_ctrl`.

## Test plan
- Reset: rst_n low mid-PEND, then release → BOOT with pc_write=0 and if_flush=1 for one cycle; RUN next cycle; perf_stall=0.
- Load-use: ex_mem_read=1, ex_dst=5, id_rs=5 → pc_write=0, if_id_write=0, id_ex_bubble=1 for 1 cycle; perf_stall=1.
- lw $8 followed by beq $8,$0 → 2 stall cycles (EX hit, then MEM hit); then pc_src=10, if_flush=1.
- Jump with imem_ready=1, id_pc_4_hi=4'h0, id_offset28=28'h0000100 → pc_write=1, pc_src=01.
- Jump with imem_ready=0 for 3 cycles, same target → PEND; pc_write=0 for 3 cycles; on ready pc_src=11, redir_pc=32'h00000100, if_flush=1.
- id_jr=1 and id_beq_taken=1 together, no hazards → pc_src=11, redir_pc=id_jr_target.
- Stall held for 2^PERF_W+2 cycles → perf_stall saturates at all-ones.
